// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues word fetches to program memory over req/ack,
// buffers {pc, instr} in a small FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and restarts fetching; an in-flight response is dropped.
module instr_fetch_queue #(
   parameter int unsigned INSTR_ADDR_WIDTH = 10,
   parameter int unsigned DEPTH            = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          imem_req,
   output logic [INSTR_ADDR_WIDTH-1:0]   imem_addr,
   input  logic                          imem_ack,
   input  logic [31:0]                   imem_data,
   input  logic                          redirect,
   input  logic [INSTR_ADDR_WIDTH-1:0]   redirect_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_instr,
   output logic [INSTR_ADDR_WIDTH-1:0]   out_pc,
   output logic [$clog2(DEPTH):0]        out_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned AW   = INSTR_ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]   pending_pc_q, pending_pc_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [AW-1:0]   pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [CntW-1:0] count_next;
   logic            credit;

   assign imem_req  = (state_q != StIdle);
   assign imem_addr = addr_q;
   assign out_valid = (count_q != '0);
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_count = count_q;

   // Redirect suppresses both FIFO ports in its cycle.
   assign pop        = out_valid && out_ready && !redirect;
   assign push       = (state_q == StReq) && imem_ack && !redirect;
   assign count_next = count_q + CntW'(push) - CntW'(pop);
   assign credit     = (count_next < CntW'(DEPTH));

   // Next-state logic: redirect takes priority over normal fetch/queue operation.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (state_q == StIdle || imem_ack) begin
            // Nothing left in flight: request the target next cycle.
            state_d    = StReq;
            addr_d     = redirect_pc;
            fetch_pc_d = redirect_pc;
         end else begin
            // Old request still outstanding: hold it until acked, remember the target.
            state_d      = StDrain;
            pending_pc_d = redirect_pc;
         end
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         count_d = count_next;
         case (state_q)
            StIdle: begin
               if (credit) begin
                  state_d = StReq;
                  addr_d  = fetch_pc_q;
               end
            end
            StReq: begin
               if (imem_ack) begin
                  fetch_pc_d = addr_q + AW'(1);
                  if (credit) addr_d  = addr_q + AW'(1);
                  else        state_d = StIdle;
               end
            end
            StDrain: begin
               if (imem_ack) begin
                  state_d    = StReq;
                  addr_d     = pending_pc_q;
                  fetch_pc_d = pending_pc_q;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         fetch_pc_q   <= '0;
         pending_pc_q <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= addr_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the core's instruction decoder. It generates word addresses to the program memory over a req/ack handshake, buffers returned instructions with their word PC in a small FIFO, and presents them to the decode stage over valid/ready. A redirect from the execute stage (taken branch, JAL, JALR) flushes the queue and restarts fetching at the new target. Any response still in flight when the redirect arrives is discarded.

## Interface
Parameters:
- INSTR_ADDR_WIDTH, default 10: width of the word address (byte address bits [1:0] excluded).
- DEPTH, default 4: FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low: block is reset on a rising clk edge where rst==0.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  INSTR_ADDR_WIDTH  word address; stable while imem_req==1.
- imem_ack  in  1  memory returns imem_data this cycle; only meaningful when imem_req==1.
- imem_data  in  32  instruction word, valid with imem_ack.
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  INSTR_ADDR_WIDTH  new word fetch address.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode consumes the head when out_valid && out_ready.
- out_instr  out  32  head instruction.
- out_pc  out  INSTR_ADDR_WIDTH  word address of the head instruction.
- out_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- State:
  - fetch_pc (next address to request).
  - pending_pc.
  - FIFO: DEPTH entries of {pc, instr}, plus read pointer, write pointer and count.
  - FSM states: IDLE, REQ, DRAIN.
- IDLE:
  - imem_req=0.
  - Go to REQ, with imem_addr<=fetch_pc, when credit is available: count_next < DEPTH.
- REQ:
  - imem_req=1, imem_addr held stable.
  - On imem_ack: push {imem_addr, imem_data}; fetch_pc <= imem_addr+1 (wraps modulo 2^INSTR_ADDR_WIDTH).
  - After the push, stay in REQ with the new address if count_next < DEPTH. Otherwise go to IDLE.
- DRAIN: a redirect arrived while a request was outstanding.
  - imem_req stays 1 with the old address until imem_ack.
  - The acknowledged data is dropped (no push).
  - Next state is REQ with imem_addr<=pending_pc.
- count_next = count + push − pop. Pop occurs on out_valid && out_ready.
- Redirect, highest priority:
  - FIFO emptied (count<=0, pointers reset). Any same-cycle pop or push is suppressed.
  - From IDLE: go to REQ with imem_addr<=redirect_pc.
  - From REQ with imem_ack the same cycle: data dropped; go to REQ with imem_addr<=redirect_pc.
  - From REQ without imem_ack: pending_pc<=redirect_pc; go to DRAIN.
  - From DRAIN with imem_ack: go to REQ with imem_addr<=redirect_pc.
  - From DRAIN without imem_ack: pending_pc<=redirect_pc, so the latest redirect wins.
- Full FIFO: no request is issued, so a push into a full FIFO is impossible. Pop and push in the same cycle are both honoured.
- Reset values: imem_req=0, imem_addr=0, fetch_pc=0, pending_pc=0, state=IDLE, out_valid=0, out_instr=0, out_pc=0, out_count=0. Reset overrides redirect and any in-flight request; a late imem_ack after reset is ignored.

## Timing
- The first request is asserted in the first cycle after rst is sampled high, with imem_addr=0.
- All outputs are registered or driven from the FIFO head; there is no combinational path from imem_data or out_ready to any output.
- Fetch latency: ack in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty (no bypass).
- Throughput: with zero-wait memory (ack in the same cycle as req) and out_ready=1, one instruction per cycle sustained. imem_req stays high and imem_addr increments every cycle.
- Redirect in cycle N:
  - out_valid=0 in cycle N+1.
  - The new target is requested in N+1, or the cycle after the draining ack.
  - The first redirected instruction is visible one cycle after its ack.

## Test plan
- Reset then 0-wait memory returning imem_data = 0x1000_0000+addr, out_ready=1 -> out_pc 0,1,2,3… on consecutive cycles starting 2 cycles after reset release, with matching out_instr.
- out_ready=0 -> exactly DEPTH (4) pushes occur, then imem_req=0 and out_count=4. Raise out_ready -> pops in order, and imem_req reasserts with addr 4 the cycle after the first pop.
- Memory with 3-cycle ack latency, redirect to 0x80 in the cycle after the request for addr 5 -> state DRAIN, addr 5 is held until its ack and dropped, then addr 0x80 is requested. The next out_pc is 0x80; addr 5 never appears at out_pc.
- Redirect coincident with imem_ack and a pop, FIFO holding 2 entries -> out_count=0 next cycle, nothing pushed, next imem_addr=redirect_pc.
- Two redirects (0x40, then 0x60) during one DRAIN -> only 0x60 is fetched.
- fetch_pc=0x3FF with INSTR_ADDR_WIDTH=10 -> next request to 0x000. Also assert rst=0 mid-REQ with a pending ack -> all outputs reset, and the stale ack produces no push.
